// File: rtl/cbus_arbiter.sv
// ============================================================================
// Module      : cbus_arbiter (plus cbus_pkg bus type definitions)
// Description : Round-robin arbiter that funnels NUM_INPUTS cache-bus
//               requesters onto a single memory-side port. One burst is
//               owned end to end, from grant to ready && last.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cbus_pkg;
    // Burst length encodings carried in the len field (memory side decodes)
    localparam logic [2:0] MLEN1  = 3'd0;
    localparam logic [2:0] MLEN2  = 3'd1;
    localparam logic [2:0] MLEN4  = 3'd2;
    localparam logic [2:0] MLEN8  = 3'd3;
    localparam logic [2:0] MLEN16 = 3'd4;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [2:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] cand;
    logic             found;

    // State, grant and priority pointer registers; reset abandons any burst
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    // Next-state: pick first valid requester from ptr upward, release on last beat
    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        found      = 1'b0;
        cand       = '0;
        case (state)
            IDLE: begin
                // Responses seen while idle are stray and deliberately ignored
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    cand = IDX_W'((int'(ptr) + i) % NUM_INPUTS);
                    if (!found && ireqs[cand].valid) begin
                        found      = 1'b1;
                        grant_next = cand;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // Beat counting belongs to the memory side; only last matters here.
                // Returning to IDLE forces one idle cycle before any new grant.
                if (oresp.ready && oresp.last) begin
                    state_next = IDLE;
                    ptr_next   = (int'(grant) == NUM_INPUTS - 1) ? '0 : grant + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output steering: granted requester is wired straight through, all others held off
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state == BUSY) begin
            oreq          = ireqs[grant];
            iresps[grant] = oresp;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
// ============================================================================
// Module      : tb_cbus_arbiter
// Description : Directed scoreboard bench for cbus_arbiter. The driver pushes
//               the expected forwarded request/response for every beat it
//               offers; a monitor pops and compares on each presented beat.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    cbus_req_t  [N-1:0]   ireqs;
    cbus_resp_t [N-1:0]   iresps;
    cbus_req_t            oreq;
    cbus_resp_t           oresp;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         granted;
        int         src;
        cbus_req_t  req;
        cbus_resp_t resp;
    } exp_t;

    exp_t sb[$];

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic cbus_req_t mkreq(input logic wr, input logic [31:0] addr, input logic [2:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 2'd2;
        r.addr     = addr;
        r.strobe   = wr ? 4'hF : 4'h0;
        r.len      = len;
        return r;
    endfunction

    // Monitor: every beat offered on oresp is matched against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && oresp.ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got beat with empty scoreboard, expected none");
                end else begin
                    e = sb.pop_front();
                    if (e.granted) begin
                        check("beat_oreq", oreq, e.req);
                        for (int i = 0; i < N; i++) begin
                            if (i == e.src) check("beat_resp_granted", iresps[i], e.resp);
                            else            check("beat_resp_holdoff", iresps[i], '0);
                        end
                    end else begin
                        check("stray_oreq", oreq, '0);
                        check("stray_iresps", iresps, '0);
                    end
                end
            end
        end
    end

    // Offer n beats to the current owner src; optionally drop its valid at beat drop_at
    task automatic beats(input int src, input int n, input bit give_last, input int drop_at);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            if (ireqs[src].is_write) ireqs[src].data = 32'hA5A5_0000 + 32'(k);
            if (k == drop_at) ireqs[src].valid = 1'b0;
            oresp.ready = 1'b1;
            oresp.last  = give_last && (k == n - 1);
            oresp.data  = 32'hD000_0000 | 32'(src << 8) | 32'(k);
            e.granted = 1'b1;
            e.src     = src;
            e.req     = ireqs[src];
            e.resp    = oresp;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        oresp = '0;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, "_oreq"}, oreq, '0);
        check({name, "_iresps"}, iresps, '0);
    endtask

    // Expects the grant to be visible now; leaves one stall cycle before beats start
    task automatic grant_check(input string name, input logic [31:0] addr);
        @(negedge clk);
        check({name, "_valid"}, oreq.valid, 1'b1);
        check({name, "_addr"}, oreq.addr, addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        ireqs  = '0;
        oresp  = '0;
        resetn = 1'b0;
        #3;
        check("reset_oreq", oreq, '0);
        check("reset_iresps", iresps, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Stray response while idle with no requests
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 32'hDEAD_BEEF;
        e.granted = 1'b0;
        e.src     = 0;
        e.req     = '0;
        e.resp    = oresp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        oresp = '0;
        idle_check("stray_after");
        @(posedge clk);
        #1;

        // Single 16-beat read on input 1
        ireqs[1] = mkreq(1'b0, 32'h8000_1000, MLEN16);
        idle_check("single_latency");
        grant_check("single_grant", 32'h8000_1000);
        beats(1, 16, 1'b1, -1);
        ireqs[1] = '0;
        idle_check("single_done");
        @(posedge clk);
        #1;

        // Write burst on input 0 with per-beat data; valid dropped mid-burst
        ireqs[0] = mkreq(1'b1, 32'h4000_0040, MLEN8);
        idle_check("write_latency");
        grant_check("write_grant", 32'h4000_0040);
        beats(0, 8, 1'b1, 3);
        ireqs[0] = '0;
        idle_check("write_done");
        @(posedge clk);
        #1;

        // Reset in the middle of a burst on input 1 (pointer is 1 at this point)
        ireqs[1] = mkreq(1'b0, 32'h8000_2000, MLEN16);
        idle_check("midrst_latency");
        grant_check("midrst_grant", 32'h8000_2000);
        beats(1, 5, 1'b0, -1);
        check("midrst_busy_valid", oreq.valid, 1'b1);
        oresp.ready = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_async_oreq", oreq, '0);
        check("midrst_async_iresps", iresps, '0);
        oresp = '0;
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        ireqs[0] = mkreq(1'b0, 32'h1000_0000, MLEN4);

        // Contention after reset: 0 first, then 1, then 0 again while 0 keeps requesting
        idle_check("postrst_idle");
        grant_check("postrst_grant0", 32'h1000_0000);
        beats(0, 4, 1'b1, -1);
        idle_check("rr_gap1");
        grant_check("rr_grant1", 32'h8000_2000);
        beats(1, 2, 1'b1, -1);
        ireqs[1] = '0;
        idle_check("rr_gap2");
        grant_check("rr_grant0_again", 32'h1000_0000);
        beats(0, 1, 1'b1, -1);
        ireqs[0] = '0;
        idle_check("final_idle");
        @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, number of cache-bus requesters (2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset; one clock, reset asynchronous active-low.
REQ-004 SHALL have port ireqs  input  cbus_req_t[NUM_INPUTS]  requests from upstream buffers/caches.
REQ-005 SHALL have port iresps  output  cbus_resp_t[NUM_INPUTS]  per-requester responses.
REQ-006 SHALL have port oreq  output  cbus_req_t  single request to memory side.
REQ-007 SHALL have port oresp  input  cbus_resp_t  memory-side response (ready, last, data).

Function
REQ-008 SHALL implement FSM with states IDLE and BUSY, plus registered grant index (width clog2(NUM_INPUTS)) and round-robin priority pointer.
REQ-009 In IDLE, oreq SHALL be all-zero and every iresps[i] SHALL be all-zero.
REQ-010 In IDLE with any ireqs[i].valid high, SHALL select first valid index scanning from pointer upward, wrapping modulo NUM_INPUTS; register it as grant and enter BUSY next edge.
REQ-011 In IDLE with no valid request, SHALL stay IDLE; grant and pointer unchanged.
REQ-012 Grant latency SHALL be exactly one cycle: request valid at edge N is forwarded on oreq from cycle N+1.
REQ-013 In BUSY, oreq SHALL equal ireqs[grant] combinationally (all fields: valid, is_write, size, addr, strobe, data, len).
REQ-014 In BUSY, iresps[grant] SHALL equal oresp combinationally; all other iresps SHALL be all-zero (ready=0, last=0, data=0).
REQ-015 Requests from non-granted inputs SHALL be held off (no ready) and never reach oreq during BUSY, regardless of their valid.
REQ-016 In BUSY, when oresp.ready && oresp.last, SHALL return to IDLE next edge and set pointer to (grant+1) mod NUM_INPUTS.
REQ-017 Beats with oresp.ready && !oresp.last SHALL keep BUSY; no beat counting inside arbiter (len is memory side's concern).
REQ-018 If granted requester drops valid mid-burst (protocol violation), SHALL keep forwarding and stay BUSY until ready && last.
REQ-019 After burst completion SHALL always spend at least one IDLE cycle before next grant, so a requester dropping valid the cycle after last is never re-granted.
REQ-020 Simultaneous requests SHALL be served in round-robin order; no requester waits more than NUM_INPUTS-1 bursts once valid.
REQ-021 oresp.ready/last while IDLE SHALL be ignored and not change state.

Reset
REQ-022 resetn low SHALL asynchronously force state=IDLE, grant=0, pointer=0; oreq immediately all-zero, all iresps all-zero.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration restarts from pointer 0.
REQ-024 First edge after resetn rises SHALL perform normal IDLE arbitration.

Verification
REQ-025 Single request: ireqs[1] read, len=MLEN16, addr=0x80001000 -> oreq.valid=1 from next cycle with same addr; 16 ready beats, last on 16th; iresps[1].data matches each beat; IDLE after.
REQ-026 Contention: ireqs[0] and ireqs[1] valid same cycle after reset -> input 0 granted first, then 1 after one IDLE cycle; with 0 re-requesting, 1 still served second, then 0.
REQ-027 Hold-off: while input 0 is BUSY, iresps[1].ready stays 0 for whole burst despite oresp.ready pulses.
REQ-028 Write burst: ireqs[0] is_write=1, strobe=4'b1111, data changing per beat -> oreq.data tracks ireqs[0].data each cycle; completes on ready&&last.
REQ-029 Reset mid-burst: resetn low after beat 5 of 16 -> oreq.valid=0 same cycle (no clock edge needed); after release, request on input 1 granted normally.
REQ-030 Stray response: oresp.ready=1, last=1 in IDLE with no requests -> state stays IDLE, all outputs zero.
